// File: rtl/ps2_mouse_kempston.sv
// rtl/ps2_mouse_kempston.sv - PS/2 3-byte mouse packet parser feeding Kempston mouse registers
module ps2_mouse_kempston #(
  parameter int TIMEOUT_CYCLES = 2800000,
  parameter int SHIFT          = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       mouse_strobe,
  input  logic [7:0] mouse_data,
  output logic [7:0] kmouse_x,
  output logic [7:0] kmouse_y,
  output logic [7:0] kmouse_buttons,
  output logic       packet_valid,
  output logic       sync_error
);

  localparam logic [1:0] WAIT_B0 = 2'd0;
  localparam logic [1:0] WAIT_B1 = 2'd1;
  localparam logic [1:0] WAIT_B2 = 2'd2;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_btn;     // b0[2:0]: middle, right, left
  logic          r_sx;      // b0[4]: X sign
  logic          r_sy;      // b0[5]: Y sign
  logic          r_ovx;     // b0[6]: X overflow
  logic          r_ovy;     // b0[7]: Y overflow
  logic [7:0]    r_b1;
  logic [7:0]    r_x;
  logic [7:0]    r_y;
  logic [7:0]    r_buttons;
  logic          r_pv;
  logic          r_se;
  logic [7:0]    w_dx;
  logic [7:0]    w_dy;

  // 9-bit sign/magnitude pair -> clamped to 8-bit signed range, then scaled down
  function automatic logic [7:0] clamp_shift(input logic sgn, input logic [7:0] mag);
    logic signed [7:0] c;
    if (sgn != mag[7]) c = sgn ? 8'sh80 : 8'sh7F;
    else               c = $signed(mag);
    return c >>> SHIFT;
  endfunction

  // Y delta uses the live third byte so the update lands on the b2 strobe edge
  assign w_dx = clamp_shift(r_sx, r_b1);
  assign w_dy = clamp_shift(r_sy, mouse_data);

  // Packet framing, inter-byte timeout and register accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WAIT_B0;
      r_cnt     <= '0;
      r_btn     <= '0;
      r_sx      <= 1'b0;
      r_sy      <= 1'b0;
      r_ovx     <= 1'b0;
      r_ovy     <= 1'b0;
      r_b1      <= 8'h00;
      r_x       <= 8'h00;
      r_y       <= 8'h00;
      r_buttons <= 8'hFF;
      r_pv      <= 1'b0;
      r_se      <= 1'b0;
    end else begin
      r_pv <= 1'b0;
      r_se <= 1'b0;
      if (!enable) begin
        r_state <= WAIT_B0;
        r_cnt   <= '0;
      end else if (mouse_strobe) begin
        // a strobe always beats a coincident timeout
        r_cnt <= '0;
        case (r_state)
          WAIT_B0: begin
            if (mouse_data[3]) begin
              r_btn   <= mouse_data[2:0];
              r_sx    <= mouse_data[4];
              r_sy    <= mouse_data[5];
              r_ovx   <= mouse_data[6];
              r_ovy   <= mouse_data[7];
              r_state <= WAIT_B1;
            end else begin
              r_se <= 1'b1;
            end
          end
          WAIT_B1: begin
            r_b1    <= mouse_data;
            r_state <= WAIT_B2;
          end
          WAIT_B2: begin
            if (!r_ovx) r_x <= r_x + w_dx;
            if (!r_ovy) r_y <= r_y + w_dy;
            r_buttons <= {5'b11111, ~r_btn[2], ~r_btn[0], ~r_btn[1]};
            r_pv      <= 1'b1;
            r_state   <= WAIT_B0;
          end
          default: r_state <= WAIT_B0;
        endcase
      end else if (r_state != WAIT_B0) begin
        if (r_cnt == TO_LAST) begin
          r_state <= WAIT_B0;
          r_cnt   <= '0;
          r_se    <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign kmouse_x       = r_x;
  assign kmouse_y       = r_y;
  assign kmouse_buttons = r_buttons;
  assign packet_valid   = r_pv;
  assign sync_error     = r_se;

endmodule

// File: tb/tb_ps2_mouse_kempston.sv
// tb/tb_ps2_mouse_kempston.sv - randomized and directed check of ps2_mouse_kempston against a packet-level model
`timescale 1ns/1ps
module tb_ps2_mouse_kempston;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       mouse_strobe = 1'b0;
  logic [7:0] mouse_data = 8'h00;

  logic [7:0] x0, y0, b0, x1, y1, b1;
  logic       pv0, se0, pv1, se1;

  int total = 0;
  int bad   = 0;

  ps2_mouse_kempston #(.TIMEOUT_CYCLES(TO), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mouse_strobe(mouse_strobe),
    .mouse_data(mouse_data), .kmouse_x(x0), .kmouse_y(y0), .kmouse_buttons(b0),
    .packet_valid(pv0), .sync_error(se0));

  ps2_mouse_kempston #(.TIMEOUT_CYCLES(TO), .SHIFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mouse_strobe(mouse_strobe),
    .mouse_data(mouse_data), .kmouse_x(x1), .kmouse_y(y1), .kmouse_buttons(b1),
    .packet_valid(pv1), .sync_error(se1));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] pkt[$];
  int         idle = 0;
  int         mx[2] = '{0, 0};
  int         my[2] = '{0, 0};
  int         mbtn = 255;
  bit         mpv = 0;
  bit         mse = 0;

  function automatic int delta(input bit sgn, input int mag, input int sh);
    int d;
    d = mag - (sgn ? 256 : 0);
    if (d < -128) d = -128;
    if (d > 127)  d = 127;
    return d >>> sh;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      pkt.delete(); idle = 0;
      mx = '{0, 0}; my = '{0, 0}; mbtn = 255; mpv = 0; mse = 0;
    end else begin
      mpv = 0; mse = 0;
      if (!enable) begin
        pkt.delete(); idle = 0;
      end else if (mouse_strobe) begin
        idle = 0;
        if (pkt.size() == 0) begin
          if (mouse_data[3]) pkt.push_back(mouse_data);
          else mse = 1;
        end else if (pkt.size() == 1) begin
          pkt.push_back(mouse_data);
        end else begin
          for (int s = 0; s < 2; s++) begin
            if (!pkt[0][6]) mx[s] = (mx[s] + delta(pkt[0][4], int'(pkt[1]), s)) & 255;
            if (!pkt[0][7]) my[s] = (my[s] + delta(pkt[0][5], int'(mouse_data), s)) & 255;
          end
          // active low: bit2 middle, bit1 left, bit0 right
          mbtn = 248 + (pkt[0][2] ? 0 : 4) + (pkt[0][0] ? 0 : 2) + (pkt[0][1] ? 0 : 1);
          mpv = 1;
          pkt.delete();
        end
      end else if (pkt.size() != 0) begin
        if (idle == TO - 1) begin
          pkt.delete(); idle = 0; mse = 1;
        end else begin
          idle++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("dut0 {x,y,btn,pv,se}", {6'd0, x0, y0, b0, pv0, se0},
          {6'd0, mx[0][7:0], my[0][7:0], mbtn[7:0], mpv, mse});
    check("dut1 {x,y,btn,pv,se}", {6'd0, x1, y1, b1, pv1, se1},
          {6'd0, mx[1][7:0], my[1][7:0], mbtn[7:0], mpv, mse});
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] d);
    mouse_strobe = 1'b1;
    mouse_data   = d;
    @(negedge clk);
    mouse_strobe = 1'b0;
    mouse_data   = 8'h00;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset x",   {24'd0, x0}, 32'h00);
    check("reset btn", {24'd0, b0}, 32'hFF);

    // basic packet
    send3(8'h08, 8'h05, 8'h03);
    check("t1 x", {24'd0, x0}, 32'h05);
    check("t1 y", {24'd0, y0}, 32'h03);
    check("t1 btn", {24'd0, b0}, 32'hFF);

    // left button, then negative dx
    send3(8'h09, 8'h00, 8'h00);
    check("t2 btn", {24'd0, b0}, 32'hFD);
    check("t2 x hold", {24'd0, x0}, 32'h05);
    send3(8'h18, 8'hFB, 8'h00);
    check("t2 x neg", {24'd0, x0}, 32'h00);

    // resync on a byte without bit3
    do_reset();
    send_byte(8'h00);
    send3(8'h08, 8'h05, 8'h03);
    check("t3 x", {24'd0, x0}, 32'h05);
    check("t3 y", {24'd0, y0}, 32'h03);

    // X overflow flag, then clamp of -256
    send3(8'h48, 8'hFF, 8'h02);
    check("t4 x ovf", {24'd0, x0}, 32'h05);
    check("t4 y", {24'd0, y0}, 32'h05);
    do_reset();
    send3(8'h18, 8'h00, 8'h00);
    check("t4 clamp x0", {24'd0, x0}, 32'h80);
    check("t4 clamp x1", {24'd0, x1}, 32'hC0);

    // timeout drops the partial packet
    do_reset();
    send_byte(8'h08); send_byte(8'h05);
    repeat (TO) @(negedge clk);
    send_byte(8'h03);
    check("t5 no update", {24'd0, x0}, 32'h00);
    send3(8'h08, 8'h05, 8'h03);
    check("t5 x", {24'd0, x0}, 32'h05);
    // strobe on the timeout cycle is accepted
    send_byte(8'h08); send_byte(8'h05);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h03);
    check("t5 edge x", {24'd0, x0}, 32'h0A);
    check("t5 edge y", {24'd0, y0}, 32'h06);

    // SHIFT=1 scaling and enable abort
    do_reset();
    send3(8'h08, 8'h07, 8'h00);
    check("t6 x1", {24'd0, x1}, 32'h03);
    check("t6 x0", {24'd0, x0}, 32'h07);
    send_byte(8'h08); send_byte(8'h07);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    send_byte(8'h00);
    check("t6 abort x1", {24'd0, x1}, 32'h03);
    send3(8'h08, 8'h07, 8'h00);
    check("t6 next x1", {24'd0, x1}, 32'h06);

    // reset asserted mid-packet
    send_byte(8'h08); send_byte(8'h07);
    #3 rst_n = 1'b0;
    #1 check("t7 async x", {24'd0, x0}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        enable = 1'b1;
      end
      mouse_strobe = ($urandom_range(0, 2) == 0);
      mouse_data   = 8'($urandom);
      if ($urandom_range(0, 1) == 1) mouse_data[3] = 1'b1;
      if ($urandom_range(0, 3) != 0) mouse_data[7:6] = 2'b00;
      @(negedge clk);
      mouse_strobe = 1'b0;
      if ($urandom_range(0, 99) == 0) repeat (TO - 2 + $urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
